// File: rtl/snoop_bus_arbiter_if.sv
// Bus bundle between the snoop arbiter and its caches/memory.
// slave = arbiter side, master = caches/memory side.
interface snoop_bus_arbiter_if;
  logic [8:0] req1;
  logic [8:0] req2;
  logic [8:0] req3;
  logic [8:0] memOut;
  logic [8:0] bus;
  logic [2:0] grant;
  logic       busy;
  logic       timeout_err;

  modport slave (
    input  req1, req2, req3, memOut,
    output bus, grant, busy, timeout_err
  );

  modport master (
    output req1, req2, req3, memOut,
    input  bus, grant, busy, timeout_err
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter for three caches plus a memory reply path.
// Optional memory-wait timeout (ERR state) enabled by macro ARB_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no transaction, looking for a pending request
// GRANT    | winner's word broadcast for one cycle
// WAIT_MEM | miss outstanding, waiting for a valid memOut
// RESP     | memory reply broadcast for one cycle
// ERR      | memory wait expired (ARB_TIMEOUT_EN only), one cycle
module snoop_bus_arbiter #(
  parameter int         TIMEOUT = 15,
  parameter logic [1:0] MEM_ID  = 2'b00
) (
  input logic           clock,
  input logic           reset,
  snoop_bus_arbiter_if.slave bif
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_bad
    $error("snoop_bus_arbiter: TIMEOUT must be 1..255");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
`ifdef ARB_TIMEOUT_EN
  localparam logic [2:0] S_ERR   = 3'd4;
  localparam logic [7:0] TC_LOAD = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`endif

  logic [2:0] state;
  logic [1:0] ptr;
  logic [1:0] win;
  logic [1:0] word_op;
  logic [4:0] word_addr;
  logic [1:0] mem_op;
  logic [4:0] mem_addr;

  logic [3:0] pend;
  logic [1:0] pick;
  logic [1:0] idx;
  logic [8:0] pick_word;
  logic       mem_vld;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Scan from ptr+2 down to ptr so the pointer position wins last.
  always_comb begin
    pend = {1'b0, bif.req3[8:7] != 2'b00, bif.req2[8:7] != 2'b00,
            bif.req1[8:7] != 2'b00};
    pick = ptr;
    idx  = ptr;
    for (int k = 2; k >= 0; k--) begin
      idx = wrap3({1'b0, ptr} + 3'(k));
      if (pend[idx]) pick = idx;
    end
    case (pick)
      2'd0:    pick_word = bif.req1;
      2'd1:    pick_word = bif.req2;
      default: pick_word = bif.req3;
    endcase
  end

  assign mem_vld = bif.memOut[8:7] != 2'b00;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      win       <= 2'd0;
      word_op   <= 2'b00;
      word_addr <= 5'd0;
      mem_op    <= 2'b00;
      mem_addr  <= 5'd0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt  <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|pend) begin
            win       <= pick;
            word_op   <= pick_word[8:7];
            word_addr <= pick_word[4:0];
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          ptr   <= (win == 2'd2) ? 2'd0 : win + 2'd1;
          state <= (word_op == 2'b11) ? S_IDLE : S_WAIT;
`ifdef ARB_TIMEOUT_EN
          wait_cnt <= TC_LOAD;
`endif
        end
        S_WAIT: begin
          if (mem_vld) begin
            mem_op   <= bif.memOut[8:7];
            mem_addr <= bif.memOut[4:0];
            state    <= S_RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt == 8'd0) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bif.bus   = 9'h000;
    bif.grant = 3'b000;
    case (state)
      S_GRANT: begin
        bif.bus   = {word_op, win + 2'd1, word_addr};
        bif.grant = 3'b001 << win;
      end
      S_WAIT:  bif.grant = 3'b001 << win;
      S_RESP:  bif.bus   = {mem_op, MEM_ID, mem_addr};
      default: ;
    endcase
  end

  assign bif.busy = state != S_IDLE;
`ifdef ARB_TIMEOUT_EN
  assign bif.timeout_err = state == S_ERR;
`else
  assign bif.timeout_err = 1'b0;
`endif

endmodule

// File: doc/snoop_bus_arbiter.md
SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, default 15, giving the maximum memory wait in cycles (range 1..255).
REQ-002 The block SHALL expose parameter MEM_ID, default 2'b00, giving the source id that marks memory-originated bus words.
REQ-003 Port clock  input  1  SHALL be the single clock; every register SHALL update on its rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Ports req1, req2, req3  input  9 each  SHALL carry the request words of caches 1..3, formatted as [8:7] op, [6:5] src, [4:0] addr.
REQ-006 Port memOut  input  9  SHALL carry the memory reply word, which is valid when memOut[8:7] != 2'b00.
REQ-007 Port bus  output  9  SHALL carry the broadcast word snooped by all caches and memory.
REQ-008 Port grant  output  3  SHALL be a one-hot grant, where bit i-1 selects cache i.
REQ-009 Port busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-010 Port timeout_err  output  1  SHALL be a one-cycle pulse when the memory wait expires.

Function
REQ-011 Op encoding SHALL be: 00 idle, 01 read miss, 10 write miss, 11 invalidate; request i is pending when reqi[8:7] != 00.
REQ-012 The FSM SHALL have the states IDLE, GRANT, WAIT_MEM and RESP, plus ERR when ARB_TIMEOUT_EN is defined.
REQ-013 In IDLE with at least one pending request, the FSM SHALL select a winner round-robin starting at the pointer, latch the winner's word, and go to GRANT next cycle.
REQ-014 In GRANT (exactly 1 cycle), bus SHALL equal the latched word with [6:5] forced to the winner id (01/10/11), and grant SHALL be one-hot for the winner.
REQ-015 From GRANT, an invalidate (op 11) SHALL go to IDLE, and a read or write miss SHALL go to WAIT_MEM.
REQ-016 In WAIT_MEM, bus SHALL be 9'h000 and grant SHALL hold the winner; the first cycle with a valid memOut SHALL latch memOut and go to RESP.
REQ-017 In RESP (exactly 1 cycle), bus SHALL equal the latched memOut with [6:5] forced to MEM_ID, grant SHALL be 000, and the next state SHALL be IDLE.
REQ-018 The pointer SHALL update on leaving GRANT to winner+1 (mod 3), so the most recent winner gets lowest priority.
REQ-019 Request latency SHALL be: a pending request in IDLE at edge N appears on bus in cycle N+1, and the earliest return to IDLE is N+2.
REQ-020 Requests changing while busy SHALL be ignored, and requesters SHALL hold a request until granted.
REQ-021 A valid memOut outside WAIT_MEM SHALL be ignored.
REQ-022 In IDLE, bus SHALL be 9'h000 and grant SHALL be 000.
REQ-023 Three simultaneous requests after reset SHALL be granted in the order 1, 2, 3, 1, ...

Reset
REQ-024 On reset assertion, the block SHALL asynchronously force: state IDLE, bus 9'h000, grant 000, busy 0, timeout_err 0, pointer to cache 1, wait counter 0.
REQ-025 Reset asserted mid-transaction SHALL abort the transaction with no RESP issued; the first grant after release SHALL follow REQ-023.

Configuration
REQ-026 With macro ARB_TIMEOUT_EN defined, an 8-bit counter SHALL count WAIT_MEM cycles; reaching TIMEOUT without a valid memOut SHALL go to ERR.
REQ-027 ERR SHALL last exactly 1 cycle with timeout_err=1, bus 9'h000 and grant 000, then return to IDLE; the pointer SHALL keep its advanced value.
REQ-028 Without ARB_TIMEOUT_EN, WAIT_MEM SHALL wait indefinitely, the ERR state and counter SHALL be absent, and timeout_err SHALL be tied to 0.

Verification
REQ-029 Scenario: req2=9'b01_00_00101, others idle, memOut valid 3 cycles later -> GRANT bus=9'b01_10_00101, grant=010, then RESP bus=memOut with src=00, busy high 5 cycles.
REQ-030 Scenario: req1, req2 and req3 invalidates held continuously -> grant sequence 001, 010, 100, 001, with bus op=11 in each GRANT cycle.
REQ-031 Scenario: req3 invalidate=9'b11_00_01010 -> one GRANT cycle with bus=9'b11_11_01010, then IDLE with no WAIT_MEM.
REQ-032 Scenario: memOut valid during IDLE, and req1 changed during WAIT_MEM -> no bus activity from either event, and the latched word is unchanged.
REQ-033 Scenario: reset pulsed during WAIT_MEM -> bus=0, grant=000 and busy=0 immediately (asynchronously); with req3 pending after release, cache 1 ordering is restored.
REQ-034 Scenario: ARB_TIMEOUT_EN, TIMEOUT=4, read miss with no memOut -> timeout_err=1 on the 5th cycle after GRANT, then IDLE; without the macro, busy stays high.
